// File: rtl/axi_slv_pkg.sv
// Shared definitions for the memory-backed burst slave: state encodings,
// response codes and default widths.
package axi_slv_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 4;
  localparam int DEF_ID_W   = 4;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

endpackage

// File: rtl/axi_burst_slave_if.sv
// Bus bundle between the burst master and the burst slave: read request (AR),
// read data (R), write request (AW), write data (W) and write response (B).
interface axi_burst_slave_if #(
  parameter int ADDR_W = axi_slv_pkg::DEF_ADDR_W,
  parameter int DATA_W = axi_slv_pkg::DEF_DATA_W,
  parameter int LEN_W  = axi_slv_pkg::DEF_LEN_W,
  parameter int ID_W   = axi_slv_pkg::DEF_ID_W
) ();

  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic [ID_W-1:0]   ARID;

  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic              RRESP;
  logic              RLAST;
  logic [ID_W-1:0]   RID;
  logic              RIDLE;

  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [LEN_W-1:0]  AWLEN;
  logic [ID_W-1:0]   AWID;

  logic              WVALID;
  logic              WREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WLAST;

  logic              BVALID;
  logic              BREADY;
  logic [ID_W:0]     BRESP;
  logic              WIDLE;

  modport slave (
    input  ARVALID, ARADDR, ARLEN, ARID,
    output ARREADY,
    output RVALID, RDATA, RRESP, RLAST, RID, RIDLE,
    input  RREADY,
    input  AWVALID, AWADDR, AWLEN, AWID,
    output AWREADY,
    input  WVALID, WDATA, WLAST,
    output WREADY,
    output BVALID, BRESP, WIDLE,
    input  BREADY
  );

  modport master (
    output ARVALID, ARADDR, ARLEN, ARID,
    input  ARREADY,
    input  RVALID, RDATA, RRESP, RLAST, RID, RIDLE,
    output RREADY,
    output AWVALID, AWADDR, AWLEN, AWID,
    input  AWREADY,
    output WVALID, WDATA, WLAST,
    input  WREADY,
    input  BVALID, BRESP, WIDLE,
    output BREADY
  );

endinterface

// File: rtl/slv_dp_ram.sv
// Simple dual-port byte memory: one registered read port with enable and one
// synchronous write port. A read and write to the same address in the same
// cycle returns the old contents. The array has no reset.
module slv_dp_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; output holds while rd_en is low
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axi_burst_slave.sv
// Memory-backed burst slave. Independent read (AR/R) and write (AW/W/B)
// state machines share one byte array.
// Optional feature macro: AXI_SLV_BOUNDARY_ERR_EN -- when defined, bursts
// whose last beat would pass the top of the address space are flagged at
// request accept: reads return SLVERR with zero data, writes are dropped and
// answered with err=1. When undefined, addresses wrap silently.
module axi_burst_slave
  import axi_slv_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int ID_W   = DEF_ID_W
) (
  input logic               clk,
  input logic               rst,
  axi_burst_slave_if.slave  bus
);

  localparam int AW1 = ADDR_W + 1;

  // ---------------- read channel state ----------------
  r_state_t          r_state_reg, r_state_next;
  logic [ADDR_W-1:0] r_addr_reg, r_addr_next;
  logic [LEN_W-1:0]  r_len_reg, r_len_next;
  logic [LEN_W-1:0]  r_cnt_reg, r_cnt_next;
  logic [ID_W-1:0]   r_id_reg, r_id_next;
  logic              r_err_reg, r_err_next;
  logic              r_valid;

  // ---------------- write channel state ----------------
  w_state_t          w_state_reg, w_state_next;
  logic [ADDR_W-1:0] w_addr_reg, w_addr_next;
  logic [LEN_W-1:0]  w_len_reg, w_len_next;
  logic [LEN_W-1:0]  w_cnt_reg, w_cnt_next;
  logic [ID_W-1:0]   w_id_reg, w_id_next;
  logic              w_err_reg, w_err_next;
  logic              w_over_reg, w_over_next;   // beat count has passed len
  logic              w_bnd_reg, w_bnd_next;     // burst crosses top of memory
  logic              b_valid;

  // ---------------- memory port signals ----------------
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_q;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              ar_bnd_err;
  logic              aw_bnd_err;

`ifdef AXI_SLV_BOUNDARY_ERR_EN
  logic [ADDR_W:0] ar_end;
  logic [ADDR_W:0] aw_end;

  // Carry out of start+len means the burst runs past the last byte
  assign ar_end     = {1'b0, bus.ARADDR} + AW1'(bus.ARLEN);
  assign aw_end     = {1'b0, bus.AWADDR} + AW1'(bus.AWLEN);
  assign ar_bnd_err = ar_end[ADDR_W];
  assign aw_bnd_err = aw_end[ADDR_W];
`else
  assign ar_bnd_err = 1'b0;
  assign aw_bnd_err = 1'b0;
`endif

  slv_dp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_q),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Read FSM state and burst registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_reg <= R_IDLE;
      r_addr_reg  <= '0;
      r_len_reg   <= '0;
      r_cnt_reg   <= '0;
      r_id_reg    <= '0;
      r_err_reg   <= 1'b0;
    end else begin
      r_state_reg <= r_state_next;
      r_addr_reg  <= r_addr_next;
      r_len_reg   <= r_len_next;
      r_cnt_reg   <= r_cnt_next;
      r_id_reg    <= r_id_next;
      r_err_reg   <= r_err_next;
    end
  end

  // Read FSM next state; the RAM is read one beat ahead so RDATA is
  // registered in the cycle after each accept/handshake
  always_comb begin
    r_state_next = r_state_reg;
    r_addr_next  = r_addr_reg;
    r_len_next   = r_len_reg;
    r_cnt_next   = r_cnt_reg;
    r_id_next    = r_id_reg;
    r_err_next   = r_err_reg;
    rd_en        = 1'b0;
    rd_addr      = r_addr_reg + ADDR_W'(r_cnt_reg) + ADDR_W'(1);
    case (r_state_reg)
      R_IDLE: begin
        if (bus.ARVALID) begin
          r_state_next = R_DATA;
          r_addr_next  = bus.ARADDR;
          r_len_next   = bus.ARLEN;
          r_id_next    = bus.ARID;
          r_cnt_next   = '0;
          r_err_next   = ar_bnd_err;
          rd_en        = 1'b1;
          rd_addr      = bus.ARADDR;
        end
      end
      R_DATA: begin
        if (bus.RREADY) begin
          if (r_cnt_reg == r_len_reg) begin
            r_state_next = R_IDLE;
          end else begin
            r_cnt_next = r_cnt_reg + LEN_W'(1);
            rd_en      = 1'b1;
          end
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  assign r_valid     = (r_state_reg == R_DATA);
  assign bus.ARREADY = (r_state_reg == R_IDLE);
  assign bus.RIDLE   = (r_state_reg == R_IDLE);
  assign bus.RVALID  = r_valid;
  assign bus.RLAST   = r_valid && (r_cnt_reg == r_len_reg);
  assign bus.RID     = r_id_reg;
  assign bus.RRESP   = (r_valid && r_err_reg) ? RESP_SLVERR : RESP_OKAY;
  assign bus.RDATA   = (r_valid && !r_err_reg) ? rd_q : '0;

  // Write FSM state and burst registers
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_reg <= W_IDLE;
      w_addr_reg  <= '0;
      w_len_reg   <= '0;
      w_cnt_reg   <= '0;
      w_id_reg    <= '0;
      w_err_reg   <= 1'b0;
      w_over_reg  <= 1'b0;
      w_bnd_reg   <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      w_addr_reg  <= w_addr_next;
      w_len_reg   <= w_len_next;
      w_cnt_reg   <= w_cnt_next;
      w_id_reg    <= w_id_next;
      w_err_reg   <= w_err_next;
      w_over_reg  <= w_over_next;
      w_bnd_reg   <= w_bnd_next;
    end
  end

  // Write FSM next state; beats past len are dropped but the burst keeps
  // going until WLAST, and any length mismatch is reported in BRESP
  always_comb begin
    w_state_next = w_state_reg;
    w_addr_next  = w_addr_reg;
    w_len_next   = w_len_reg;
    w_cnt_next   = w_cnt_reg;
    w_id_next    = w_id_reg;
    w_err_next   = w_err_reg;
    w_over_next  = w_over_reg;
    w_bnd_next   = w_bnd_reg;
    wr_en        = 1'b0;
    wr_addr      = w_addr_reg + ADDR_W'(w_cnt_reg);
    wr_data      = bus.WDATA;
    case (w_state_reg)
      W_IDLE: begin
        if (bus.AWVALID) begin
          w_state_next = W_DATA;
          w_addr_next  = bus.AWADDR;
          w_len_next   = bus.AWLEN;
          w_id_next    = bus.AWID;
          w_cnt_next   = '0;
          w_err_next   = aw_bnd_err;
          w_over_next  = 1'b0;
          w_bnd_next   = aw_bnd_err;
        end
      end
      W_DATA: begin
        if (bus.WVALID) begin
          if (!w_over_reg) begin
            wr_en = !w_bnd_reg;
            if (w_cnt_reg == w_len_reg) begin
              w_over_next = 1'b1;
            end else begin
              w_cnt_next = w_cnt_reg + LEN_W'(1);
            end
          end else begin
            w_err_next = 1'b1;
          end
          if (bus.WLAST) begin
            w_state_next = W_RESP;
            if (w_over_reg || (w_cnt_reg != w_len_reg)) begin
              w_err_next = 1'b1;
            end
          end
        end
      end
      W_RESP: begin
        if (bus.BREADY) begin
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  assign b_valid     = (w_state_reg == W_RESP);
  assign bus.AWREADY = (w_state_reg == W_IDLE);
  assign bus.WIDLE   = (w_state_reg == W_IDLE);
  assign bus.WREADY  = (w_state_reg == W_DATA);
  assign bus.BVALID  = b_valid;
  assign bus.BRESP   = b_valid ? {w_id_reg, w_err_reg} : '0;

endmodule

// File: tb/tb_axi_burst_slave.sv
// Directed self-checking bench for axi_burst_slave. Expected values are
// hand-computed per step. Honours AXI_SLV_BOUNDARY_ERR_EN for the
// top-of-memory read step.
module tb_axi_burst_slave;

  logic clk;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rd_data [20];
  logic       rd_last [20];
  logic [3:0] rd_id   [20];
  logic       rd_resp [20];
  int         rd_count;
  logic [7:0] exp_d   [16];

  axi_burst_slave_if #(.ADDR_W(8), .DATA_W(8), .LEN_W(4), .ID_W(4)) bus ();

  axi_burst_slave #(
    .ADDR_W (8),
    .DATA_W (8),
    .LEN_W  (4),
    .ID_W   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return bus.AWREADY;
      1:       return bus.WREADY;
      2:       return bus.BVALID;
      3:       return bus.ARREADY;
      4:       return bus.RVALID;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input string tag, input int w);
    int t = 0;
    while (sel(w) !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic axi_write(input string tag, input logic [7:0] addr, input logic [3:0] len,
                           input logic [3:0] id, input int nbeats, input logic [7:0] base,
                           input int bhold, input logic [4:0] exp_bresp);
    bus.AWVALID = 1'b1;
    bus.AWADDR  = addr;
    bus.AWLEN   = len;
    bus.AWID    = id;
    wait_cond(tag, 0);
    @(negedge clk);
    bus.AWVALID = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.WVALID = 1'b1;
      bus.WDATA  = base + 8'(i);
      bus.WLAST  = (i == nbeats - 1);
      wait_cond(tag, 1);
      @(negedge clk);
    end
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
    wait_cond(tag, 2);
    for (int i = 0; i < bhold; i++) begin
      @(negedge clk);
      chk($sformatf("%s_bhold%0d", tag, i), 32'(bus.BVALID), 32'd1);
    end
    chk({tag, "_bresp"}, 32'(bus.BRESP), 32'(exp_bresp));
    $display("write %s addr=0x%02h len=%0d id=%0d beats=%0d bresp=0x%02h",
             tag, addr, len, id, nbeats, bus.BRESP);
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    chk({tag, "_bdrop"}, 32'(bus.BVALID), 32'd0);
  endtask

  task automatic axi_read(input string tag, input logic [7:0] addr, input logic [3:0] len,
                          input logic [3:0] id, input int stall_at, input int stall_n,
                          input logic [7:0] stall_exp);
    logic done;
    bus.ARVALID = 1'b1;
    bus.ARADDR  = addr;
    bus.ARLEN   = len;
    bus.ARID    = id;
    wait_cond(tag, 3);
    @(negedge clk);
    bus.ARVALID = 1'b0;
    chk({tag, "_lat"}, 32'(bus.RVALID), 32'd1);
    bus.RREADY = 1'b1;
    rd_count   = 0;
    done       = 1'b0;
    while (!done && rd_count < 20) begin
      wait_cond(tag, 4);
      if (rd_count == stall_at) begin
        bus.RREADY = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          chk($sformatf("%s_stallv%0d", tag, s), 32'(bus.RVALID), 32'd1);
          chk($sformatf("%s_stalld%0d", tag, s), 32'(bus.RDATA), 32'(stall_exp));
        end
        bus.RREADY = 1'b1;
      end
      rd_data[rd_count] = bus.RDATA;
      rd_last[rd_count] = bus.RLAST;
      rd_id[rd_count]   = bus.RID;
      rd_resp[rd_count] = bus.RRESP;
      done = bus.RLAST;
      rd_count++;
      @(negedge clk);
    end
    bus.RREADY = 1'b0;
    $display("read  %s addr=0x%02h len=%0d id=%0d beats=%0d", tag, addr, len, id, rd_count);
  endtask

  task automatic chk_burst(input string tag, input int n, input logic [3:0] id, input logic resp);
    chk({tag, "_count"}, 32'(rd_count), 32'(n));
    for (int i = 0; i < n && i < rd_count; i++) begin
      chk($sformatf("%s_d%0d", tag, i), 32'(rd_data[i]), 32'(exp_d[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(rd_last[i]), 32'(i == n - 1));
      chk($sformatf("%s_id%0d", tag, i), 32'(rd_id[i]), 32'(id));
      chk($sformatf("%s_resp%0d", tag, i), 32'(rd_resp[i]), 32'(resp));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.ARVALID = 1'b0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARID = '0;
    bus.RREADY  = 1'b0;
    bus.AWVALID = 1'b0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWID = '0;
    bus.WVALID  = 1'b0; bus.WDATA  = '0; bus.WLAST = 1'b0;
    bus.BREADY  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_arready", 32'(bus.ARREADY), 32'd1);
    chk("rst_awready", 32'(bus.AWREADY), 32'd1);
    chk("rst_ridle",   32'(bus.RIDLE),   32'd1);
    chk("rst_widle",   32'(bus.WIDLE),   32'd1);
    chk("rst_rvalid",  32'(bus.RVALID),  32'd0);
    chk("rst_rlast",   32'(bus.RLAST),   32'd0);
    chk("rst_rdata",   32'(bus.RDATA),   32'd0);
    chk("rst_wready",  32'(bus.WREADY),  32'd0);
    chk("rst_bvalid",  32'(bus.BVALID),  32'd0);
    chk("rst_bresp",   32'(bus.BRESP),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Step 1: preload 0x10..0x13 = 1..4, then 4-beat read
    axi_write("pre10", 8'h10, 4'd3, 4'd1, 4, 8'h01, 0, 5'h02);
    axi_read("t1", 8'h10, 4'd3, 4'd5, -1, 0, 8'h00);
    exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03; exp_d[3] = 8'h04;
    chk_burst("t1", 4, 4'd5, 1'b0);
    chk("t1_arready_after", 32'(bus.ARREADY), 32'd1);
    chk("t1_rvalid_after",  32'(bus.RVALID),  32'd0);

    // Step 2: single-beat write, BVALID held until BREADY, readback
    axi_write("t2", 8'h20, 4'd0, 4'd3, 1, 8'hAB, 2, 5'h06);
    axi_read("t2r", 8'h20, 4'd0, 4'd3, -1, 0, 8'h00);
    exp_d[0] = 8'hAB;
    chk_burst("t2r", 1, 4'd3, 1'b0);

    // Step 3: RREADY low for 3 cycles on beat 2 of an 8-beat read
    axi_write("pre30", 8'h30, 4'd7, 4'd2, 8, 8'h40, 0, 5'h04);
    axi_read("t3", 8'h30, 4'd7, 4'd7, 2, 3, 8'h42);
    for (int i = 0; i < 8; i++) exp_d[i] = 8'h40 + 8'(i);
    chk_burst("t3", 8, 4'd7, 1'b0);

    // Step 4: early WLAST (len=3, 2 beats) -> err, only 2 bytes written
    axi_write("pre50", 8'h50, 4'd3, 4'd0, 4, 8'h10, 0, 5'h00);
    axi_write("t4", 8'h50, 4'd3, 4'd4, 2, 8'hC0, 0, 5'h09);
    axi_read("t4r", 8'h50, 4'd3, 4'd1, -1, 0, 8'h00);
    exp_d[0] = 8'hC0; exp_d[1] = 8'hC1; exp_d[2] = 8'h12; exp_d[3] = 8'h13;
    chk_burst("t4r", 4, 4'd1, 1'b0);

    // Step 4b: late WLAST (len=0, 2 beats) -> err, extra beat dropped
    axi_write("pre60", 8'h60, 4'd1, 4'd0, 2, 8'h70, 0, 5'h00);
    axi_write("t4b", 8'h60, 4'd0, 4'd1, 2, 8'hD0, 0, 5'h03);
    axi_read("t4br", 8'h60, 4'd1, 4'd1, -1, 0, 8'h00);
    exp_d[0] = 8'hD0; exp_d[1] = 8'h71;
    chk_burst("t4br", 2, 4'd1, 1'b0);

    // Step 5: read across the top of memory
    axi_write("preFE", 8'hFE, 4'd1, 4'd0, 2, 8'hE0, 0, 5'h00);
    axi_write("pre00", 8'h00, 4'd0, 4'd0, 1, 8'hE2, 0, 5'h00);
    axi_read("t5", 8'hFE, 4'd2, 4'd9, -1, 0, 8'h00);
`ifdef AXI_SLV_BOUNDARY_ERR_EN
    exp_d[0] = 8'h00; exp_d[1] = 8'h00; exp_d[2] = 8'h00;
    chk_burst("t5", 3, 4'd9, 1'b1);
`else
    exp_d[0] = 8'hE0; exp_d[1] = 8'hE1; exp_d[2] = 8'hE2;
    chk_burst("t5", 3, 4'd9, 1'b0);
`endif

    // Concurrent AR/AW; read beat 1 and write hit 0x21 in the same cycle
    axi_write("pre21", 8'h21, 4'd0, 4'd0, 1, 8'h55, 0, 5'h00);
    bus.ARVALID = 1'b1; bus.ARADDR = 8'h20; bus.ARLEN = 4'd1; bus.ARID = 4'd2;
    bus.AWVALID = 1'b1; bus.AWADDR = 8'h21; bus.AWLEN = 4'd0; bus.AWID = 4'd2;
    chk("cc_arready", 32'(bus.ARREADY), 32'd1);
    chk("cc_awready", 32'(bus.AWREADY), 32'd1);
    @(negedge clk);
    bus.ARVALID = 1'b0; bus.AWVALID = 1'b0;
    chk("cc_rvalid", 32'(bus.RVALID), 32'd1);
    chk("cc_wready", 32'(bus.WREADY), 32'd1);
    chk("cc_rdata0", 32'(bus.RDATA), 32'h0AB);
    bus.RREADY = 1'b1;
    bus.WVALID = 1'b1; bus.WDATA = 8'h99; bus.WLAST = 1'b1;
    @(negedge clk);
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    chk("cc_rdata1_old", 32'(bus.RDATA), 32'h055);
    chk("cc_rlast",      32'(bus.RLAST), 32'd1);
    chk("cc_bvalid",     32'(bus.BVALID), 32'd1);
    chk("cc_bresp",      32'(bus.BRESP), 32'h04);
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.RREADY = 1'b0; bus.BREADY = 1'b0;
    chk("cc_rvalid_end", 32'(bus.RVALID), 32'd0);
    chk("cc_bvalid_end", 32'(bus.BVALID), 32'd0);
    $display("concurrent AR 0x20 / AW 0x21 done");
    axi_read("ccr", 8'h21, 4'd0, 4'd0, -1, 0, 8'h00);
    exp_d[0] = 8'h99;
    chk_burst("ccr", 1, 4'd0, 1'b0);

    // Step 6: reset during beat 2 of a read
    bus.ARVALID = 1'b1; bus.ARADDR = 8'h10; bus.ARLEN = 4'd3; bus.ARID = 4'd6;
    wait_cond("t6", 3);
    @(negedge clk);
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_beat2_data", 32'(bus.RDATA), 32'h03);
    rst = 1'b1;
    bus.RREADY = 1'b0;
    @(negedge clk);
    chk("t6_rvalid",  32'(bus.RVALID),  32'd0);
    chk("t6_rlast",   32'(bus.RLAST),   32'd0);
    chk("t6_arready", 32'(bus.ARREADY), 32'd1);
    chk("t6_ridle",   32'(bus.RIDLE),   32'd1);
    rst = 1'b0;
    $display("reset pulsed mid-read");
    @(negedge clk);
    axi_read("t6r", 8'h10, 4'd3, 4'd6, -1, 0, 8'h00);
    exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03; exp_d[3] = 8'h04;
    chk_burst("t6r", 4, 4'd6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
